// File: rtl/mem_lsu_if.sv
// Bundle between the execute stage, the load/store unit and the data memory.
// The LSU takes the slave view; the pipeline and memory together take the master view.
interface mem_lsu_if #(
    parameter int B_WIDTH = 32
) ();
    logic                   req_valid;
    logic                   req_ready;
    logic                   req_we;
    logic [2:0]             req_funct3;
    logic [B_WIDTH-1:0]     req_addr;
    logic [B_WIDTH-1:0]     req_wdata;

    logic                   resp_valid;
    logic                   resp_ready;
    logic [B_WIDTH-1:0]     resp_rdata;
    logic                   resp_err;

    logic [B_WIDTH-1:0]     mem_addr;
    logic                   mem_read_en;
    logic                   mem_write_en;
    logic [B_WIDTH/8-1:0]   write_byte_en;
    logic [B_WIDTH-1:0]     mem_wdata;
    logic [B_WIDTH-1:0]     mem_rdata;

    modport slave (
        input  req_valid, req_we, req_funct3, req_addr, req_wdata,
        input  resp_ready, mem_rdata,
        output req_ready, resp_valid, resp_rdata, resp_err,
        output mem_addr, mem_read_en, mem_write_en, write_byte_en, mem_wdata
    );

    modport master (
        output req_valid, req_we, req_funct3, req_addr, req_wdata,
        output resp_ready, mem_rdata,
        input  req_ready, resp_valid, resp_rdata, resp_err,
        input  mem_addr, mem_read_en, mem_write_en, write_byte_en, mem_wdata
    );
endinterface

// File: rtl/mem_lsu.sv
// Single-outstanding load/store unit: alignment check, lane steering for stores,
// shift and sign/zero extension for loads, valid/ready response to the pipeline.
//
// state      | meaning
// -----------+-----------------------------------------------------------
// S_IDLE     | req_ready high, classify and latch an incoming request
// S_RD_ISSUE | mem_read_en high for one cycle
// S_RD_WAIT  | memory data returns, shift/extend into the response register
// S_WR       | mem_write_en high for one cycle with lane-steered data
// S_RESP     | resp_valid held until resp_ready
module mem_lsu #(
    parameter int B_WIDTH = 32
) (
    input  logic      clk,
    input  logic      rst_n,
    mem_lsu_if.slave  bus
);
    typedef enum logic [2:0] {
        S_IDLE,
        S_RD_ISSUE,
        S_RD_WAIT,
        S_WR,
        S_RESP
    } state_t;

    state_t                 r_state;
    state_t                 w_next;

    logic [B_WIDTH-1:0]     r_addr;
    logic [B_WIDTH-1:0]     r_wdata;
    logic [B_WIDTH-1:0]     r_rdata;
    logic [2:0]             r_funct3;
    logic                   r_err;

    logic                   w_illegal;
    logic                   w_misalign;
    logic                   w_accept;
    logic [B_WIDTH-1:0]     w_shifted;
    logic [B_WIDTH-1:0]     w_ext;
    logic [B_WIDTH-1:0]     w_st_data;
    logic [B_WIDTH/8-1:0]   w_st_be;

    // Classification works on the live request so the error is known at the accept edge.
    always_comb begin
        w_illegal  = 1'b0;
        w_misalign = 1'b0;
        if (bus.req_we) begin
            w_illegal = bus.req_funct3[2] || (bus.req_funct3[1:0] == 2'b11);
        end else begin
            w_illegal = (bus.req_funct3 == 3'b011) || (bus.req_funct3[2:1] == 2'b11);
        end
        case (bus.req_funct3[1:0])
            2'b01:   w_misalign = bus.req_addr[0];
            2'b10:   w_misalign = |bus.req_addr[1:0];
            default: w_misalign = 1'b0;
        endcase
    end

    assign w_accept  = (r_state == S_IDLE) && bus.req_valid;
    assign w_shifted = bus.mem_rdata >> {r_addr[1:0], 3'b000};

    always_comb begin
        w_ext = '0;
        case (r_funct3)
            3'b000:  w_ext = {{24{w_shifted[7]}},  w_shifted[7:0]};
            3'b001:  w_ext = {{16{w_shifted[15]}}, w_shifted[15:0]};
            3'b010:  w_ext = w_shifted;
            3'b100:  w_ext = {24'h0, w_shifted[7:0]};
            3'b101:  w_ext = {16'h0, w_shifted[15:0]};
            default: w_ext = '0;
        endcase
    end

    always_comb begin
        w_st_data = r_wdata;
        w_st_be   = 4'b1111;
        case (r_funct3[1:0])
            2'b00: begin
                w_st_data = {4{r_wdata[7:0]}};
                w_st_be   = 4'b0001 << r_addr[1:0];
            end
            2'b01: begin
                w_st_data = {2{r_wdata[15:0]}};
                w_st_be   = r_addr[1] ? 4'b1100 : 4'b0011;
            end
            default: begin
                w_st_data = r_wdata;
                w_st_be   = 4'b1111;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next            = r_state;
        bus.req_ready     = 1'b0;
        bus.resp_valid    = 1'b0;
        bus.mem_read_en   = 1'b0;
        bus.mem_write_en  = 1'b0;
        bus.write_byte_en = '0;
        bus.mem_wdata     = '0;
        case (r_state)
            S_IDLE: begin
                bus.req_ready = 1'b1;
                if (bus.req_valid) begin
                    if (w_illegal || w_misalign) begin
                        w_next = S_RESP;
                    end else if (bus.req_we) begin
                        w_next = S_WR;
                    end else begin
                        w_next = S_RD_ISSUE;
                    end
                end
            end
            S_RD_ISSUE: begin
                bus.mem_read_en = 1'b1;
                w_next          = S_RD_WAIT;
            end
            S_RD_WAIT: begin
                w_next = S_RESP;
            end
            S_WR: begin
                bus.mem_write_en  = 1'b1;
                bus.write_byte_en = w_st_be;
                bus.mem_wdata     = w_st_data;
                w_next            = S_RESP;
            end
            S_RESP: begin
                bus.resp_valid = 1'b1;
                if (bus.resp_ready) begin
                    w_next = S_IDLE;
                end
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    // Response data is cleared on accept so stores and errors report zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_addr   <= '0;
            r_wdata  <= '0;
            r_rdata  <= '0;
            r_funct3 <= '0;
            r_err    <= 1'b0;
        end else if (w_accept) begin
            r_addr   <= bus.req_addr;
            r_wdata  <= bus.req_wdata;
            r_funct3 <= bus.req_funct3;
            r_err    <= w_illegal || w_misalign;
            r_rdata  <= '0;
        end else if (r_state == S_RD_WAIT) begin
            r_rdata  <= w_ext;
        end
    end

    assign bus.mem_addr   = {2'b00, r_addr[B_WIDTH-1:2]};
    assign bus.resp_rdata = r_rdata;
    assign bus.resp_err   = r_err;
endmodule

// File: tb/tb_mem_lsu.sv
// Directed bench for mem_lsu: a small word memory model behind the unit and a
// scoreboard of expected responses pushed at request time, popped at response time.
module tb_mem_lsu;
    logic clk;
    logic rst_n;

    mem_lsu_if #(.B_WIDTH(32)) bus ();

    mem_lsu #(.B_WIDTH(32)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    logic [31:0] mem [16];
    logic [31:0] mrd;
    logic        bd_we;
    logic [3:0]  bd_idx;
    logic [31:0] bd_data;

    assign bus.mem_rdata = mrd;

    always @(posedge clk) begin
        if (bd_we) mem[bd_idx] <= bd_data;
        if (bus.mem_write_en) begin
            for (int b = 0; b < 4; b++) begin
                if (bus.write_byte_en[b]) mem[bus.mem_addr[3:0]][8*b +: 8] <= bus.mem_wdata[8*b +: 8];
            end
        end
        if (bus.mem_read_en) mrd <= mem[bus.mem_addr[3:0]];
    end

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          lat;
        int          rd;
        int          wr;
    } exp_t;

    exp_t sb[$];
    int   n_cmp;
    int   n_err;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic preload(input logic [3:0] idx, input logic [31:0] data);
        @(negedge clk);
        bd_we   = 1'b1;
        bd_idx  = idx;
        bd_data = data;
        @(posedge clk);
        #1 bd_we = 1'b0;
    endtask

    task automatic do_req(input string tag, input logic we, input logic [2:0] f3,
                          input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [31:0] exp_rdata, input logic exp_err, input int exp_lat,
                          input logic [3:0] exp_be, input logic [31:0] exp_mw,
                          input logic [31:0] exp_ma, input int hold);
        exp_t e;
        exp_t got;
        int   lat;
        int   rd;
        int   wr;
        int   both;
        bit   seen;
        logic [31:0] held;
        lat  = 0;
        rd   = 0;
        wr   = 0;
        both = 0;
        seen = 1'b0;
        @(negedge clk);
        chk({tag, "_req_ready"}, 32'(bus.req_ready), 32'd1);
        bus.req_valid  = 1'b1;
        bus.req_we     = we;
        bus.req_funct3 = f3;
        bus.req_addr   = addr;
        bus.req_wdata  = wdata;
        e.rdata = exp_rdata;
        e.err   = exp_err;
        e.lat   = exp_lat;
        e.rd    = (!exp_err && !we) ? 1 : 0;
        e.wr    = (!exp_err && we) ? 1 : 0;
        sb.push_back(e);
        @(posedge clk);
        #1 bus.req_valid = 1'b0;
        for (int c = 0; c < 10 && !seen; c++) begin
            @(negedge clk);
            lat++;
            if (bus.mem_read_en) rd++;
            if (bus.mem_read_en && bus.mem_write_en) both++;
            if (bus.mem_write_en) begin
                wr++;
                chk({tag, "_be"},    32'(bus.write_byte_en), 32'(exp_be));
                chk({tag, "_mwdata"}, bus.mem_wdata, exp_mw);
                chk({tag, "_maddr"},  bus.mem_addr,  exp_ma);
            end
            if (bus.resp_valid) seen = 1'b1;
        end
        chk({tag, "_resp_seen"}, 32'(seen), 32'd1);
        got = sb.pop_front();
        chk({tag, "_latency"},  32'(lat), 32'(got.lat));
        chk({tag, "_rdata"},    bus.resp_rdata, got.rdata);
        chk({tag, "_err"},      32'(bus.resp_err), 32'(got.err));
        chk({tag, "_rd_count"}, 32'(rd), 32'(got.rd));
        chk({tag, "_wr_count"}, 32'(wr), 32'(got.wr));
        chk({tag, "_rd_wr_overlap"}, 32'(both), 32'd0);
        held = bus.resp_rdata;
        for (int h = 0; h < hold; h++) begin
            bus.req_valid  = 1'b1;
            bus.req_we     = 1'b1;
            bus.req_funct3 = 3'b010;
            bus.req_addr   = 32'h0000_0000;
            bus.req_wdata  = 32'hFFFF_FFFF;
            @(negedge clk);
            chk({tag, "_hold_valid"}, 32'(bus.resp_valid), 32'd1);
            chk({tag, "_hold_rdata"}, bus.resp_rdata, held);
            chk({tag, "_hold_ready"}, 32'(bus.req_ready), 32'd0);
            chk({tag, "_hold_mem"},   32'(bus.mem_write_en | bus.mem_read_en), 32'd0);
        end
        bus.req_valid  = 1'b0;
        bus.resp_ready = 1'b1;
        @(negedge clk);
        bus.resp_ready = 1'b0;
        chk({tag, "_retire_ready"}, 32'(bus.req_ready), 32'd1);
        chk({tag, "_retire_valid"}, 32'(bus.resp_valid), 32'd0);
    endtask

    initial begin
        n_cmp          = 0;
        n_err          = 0;
        bd_we          = 1'b0;
        bd_idx         = '0;
        bd_data        = '0;
        bus.req_valid  = 1'b0;
        bus.req_we     = 1'b0;
        bus.req_funct3 = 3'b000;
        bus.req_addr   = '0;
        bus.req_wdata  = '0;
        bus.resp_ready = 1'b0;
        rst_n          = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_req_ready",  32'(bus.req_ready),     32'd1);
        chk("rst_resp_valid", 32'(bus.resp_valid),    32'd0);
        chk("rst_resp_err",   32'(bus.resp_err),      32'd0);
        chk("rst_resp_rdata", bus.resp_rdata,         32'd0);
        chk("rst_rd_en",      32'(bus.mem_read_en),   32'd0);
        chk("rst_wr_en",      32'(bus.mem_write_en),  32'd0);
        chk("rst_be",         32'(bus.write_byte_en), 32'd0);
        chk("rst_maddr",      bus.mem_addr,           32'd0);
        chk("rst_mwdata",     bus.mem_wdata,          32'd0);
        rst_n = 1'b1;

        preload(4'd0, 32'h0000_0000);
        preload(4'd1, 32'h0000_0000);

        do_req("sb5", 1'b1, 3'b000, 32'h5, 32'h1234_56AB, 32'h0, 1'b0, 2, 4'b0010, 32'hABAB_ABAB, 32'h1, 0);
        @(negedge clk);
        chk("sb5_mem_word1", mem[1], 32'h0000_AB00);

        preload(4'd1, 32'h80FF_7F01);
        do_req("lb7",  1'b0, 3'b000, 32'h7, 32'h0, 32'hFFFF_FF80, 1'b0, 3, 4'b0, 32'h0, 32'h0, 0);
        do_req("lbu7", 1'b0, 3'b100, 32'h7, 32'h0, 32'h0000_0080, 1'b0, 3, 4'b0, 32'h0, 32'h0, 0);
        do_req("lh4",  1'b0, 3'b001, 32'h4, 32'h0, 32'h0000_7F01, 1'b0, 3, 4'b0, 32'h0, 32'h0, 0);
        do_req("lw4",  1'b0, 3'b010, 32'h4, 32'h0, 32'h80FF_7F01, 1'b0, 3, 4'b0, 32'h0, 32'h0, 0);
        do_req("lb5",  1'b0, 3'b000, 32'h5, 32'h0, 32'h0000_007F, 1'b0, 3, 4'b0, 32'h0, 32'h0, 0);

        do_req("lh3_err",   1'b0, 3'b001, 32'h3, 32'h0, 32'h0, 1'b1, 1, 4'b0, 32'h0, 32'h0, 0);
        do_req("sw2_err",   1'b1, 3'b010, 32'h2, 32'h5555_5555, 32'h0, 1'b1, 1, 4'b0, 32'h0, 32'h0, 0);
        do_req("ld011_err", 1'b0, 3'b011, 32'h4, 32'h0, 32'h0, 1'b1, 1, 4'b0, 32'h0, 32'h0, 0);
        do_req("st100_err", 1'b1, 3'b100, 32'h4, 32'h0, 32'h0, 1'b1, 1, 4'b0, 32'h0, 32'h0, 0);
        chk("err_mem_word1", mem[1], 32'h80FF_7F01);

        do_req("sh6",   1'b1, 3'b001, 32'h6, 32'hDEAD_BEEF, 32'h0, 1'b0, 2, 4'b1100, 32'hBEEF_BEEF, 32'h1, 0);
        do_req("lhu6",  1'b0, 3'b101, 32'h6, 32'h0, 32'h0000_BEEF, 1'b0, 3, 4'b0, 32'h0, 32'h0, 0);
        do_req("lh6",   1'b0, 3'b001, 32'h6, 32'h0, 32'hFFFF_BEEF, 1'b0, 3, 4'b0, 32'h0, 32'h0, 0);
        do_req("bp_lw", 1'b0, 3'b010, 32'h4, 32'h0, 32'hBEEF_7F01, 1'b0, 3, 4'b0, 32'h0, 32'h0, 5);
        chk("bp_mem_word0", mem[0], 32'h0000_0000);

        // Reset while the read strobe is up.
        begin
            int seen_v;
            int seen_r;
            seen_v = 0;
            seen_r = 0;
            @(negedge clk);
            bus.req_valid  = 1'b1;
            bus.req_we     = 1'b0;
            bus.req_funct3 = 3'b010;
            bus.req_addr   = 32'h4;
            @(posedge clk);
            #1 bus.req_valid = 1'b0;
            chk("rst_mid_rd_issue", 32'(bus.mem_read_en), 32'd1);
            #1 rst_n = 1'b0;
            #1;
            chk("rst_mid_rd_drop",  32'(bus.mem_read_en), 32'd0);
            chk("rst_mid_ready",    32'(bus.req_ready),   32'd1);
            @(negedge clk);
            rst_n = 1'b1;
            bus.resp_ready = 1'b1;
            repeat (6) begin
                @(negedge clk);
                if (bus.resp_valid) seen_v++;
                if (bus.mem_read_en) seen_r++;
            end
            bus.resp_ready = 1'b0;
            chk("rst_mid_no_resp", 32'(seen_v), 32'd0);
            chk("rst_mid_no_read", 32'(seen_r), 32'd0);
        end

        // Reset while the write strobe is up, before its write edge.
        preload(4'd2, 32'h1122_3344);
        @(negedge clk);
        bus.req_valid  = 1'b1;
        bus.req_we     = 1'b1;
        bus.req_funct3 = 3'b010;
        bus.req_addr   = 32'h8;
        bus.req_wdata  = 32'hCAFE_F00D;
        @(posedge clk);
        #1 bus.req_valid = 1'b0;
        chk("rst_wr_strobe", 32'(bus.mem_write_en), 32'd1);
        #1 rst_n = 1'b0;
        #1;
        chk("rst_wr_drop", 32'(bus.mem_write_en), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_wr_not_written", mem[2], 32'h1122_3344);
        chk("rst_wr_idle",        32'(bus.req_ready), 32'd1);

        chk("sb_empty", 32'(sb.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/mem_lsu.md
# mem_lsu

Load/store unit for TRV-32I that sits directly upstream of the data memory. Accepts one load or store request from the execute stage, checks alignment, drives word address, read/write enables, byte enables and lane-aligned write data to the data memory, then sign/zero-extends the returned word. Handles one outstanding request at a time and completes it with a valid/ready response back to the pipeline.

## Interface
- B_WIDTH, 32, data/address width; only 32 is supported.
- clk  in  1  clock, all state on rising edge.
- rst  in  1  asynchronous, active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  unit can accept a request; high only in IDLE.
- req_we  in  1  1 = store, 0 = load.
- req_funct3  in  3  RV32I funct3 (LB/LH/LW/LBU/LHU, SB/SH/SW).
- req_addr  in  B_WIDTH  byte address.
- req_wdata  in  B_WIDTH  store data, right-justified.
- resp_valid  out  1  response present; held until accepted.
- resp_ready  in  1  consumer accepts the response.
- resp_rdata  out  B_WIDTH  extended load data; 0 for stores and errors.
- resp_err  out  1  misaligned address or illegal funct3.
- mem_addr  out  B_WIDTH  word index (req_addr >> 2).
- mem_read_en  out  1  memory read strobe.
- mem_write_en  out  1  memory write strobe.
- write_byte_en  out  B_WIDTH/8  byte lane enables.
- mem_wdata  out  B_WIDTH  lane-replicated store data; the integration top drives the memory data bus from it while mem_write_en is high.
- mem_rdata  in  B_WIDTH  memory read data, valid the cycle after mem_read_en.

## Operation
- States: IDLE, RD_ISSUE, RD_WAIT, WR, RESP.
- IDLE: req_ready=1. On req_valid, latch addr/we/funct3/wdata and classify:
  - Illegal: load funct3 in {011,110,111}, or store funct3 not in {000,001,010} → resp_err=1, go to RESP.
  - Misaligned: half with addr[0]=1, or word with addr[1:0]≠0 → resp_err=1, go to RESP.
  - Otherwise load → RD_ISSUE, store → WR.
- Errored requests never assert mem_read_en or mem_write_en.
- RD_ISSUE (1 cycle): mem_read_en=1, mem_addr valid. Next state RD_WAIT.
- RD_WAIT (1 cycle): shift mem_rdata right by 8·addr[1:0] and extend into resp_rdata. LB/LH sign-extend from bit 7/15; LBU/LHU zero-extend; LW passes through. Next state RESP.
- WR (1 cycle): mem_write_en=1.
  - SB: mem_wdata = wdata[7:0] replicated ×4, write_byte_en = 1 << addr[1:0].
  - SH: mem_wdata = wdata[15:0] replicated ×2, write_byte_en = addr[1] ? 1100 : 0011.
  - SW: mem_wdata = wdata, write_byte_en = 1111.
  - Next state RESP.
- RESP: resp_valid=1; resp_rdata/resp_err stable. On resp_ready, go to IDLE.
- mem_read_en and mem_write_en are never high together. Both are 0 outside RD_ISSUE/WR.
- write_byte_en and mem_wdata are 0 outside WR.

## Timing
- Reset (rst=0): state IDLE immediately. req_ready=1, resp_valid=0, resp_err=0, resp_rdata=0, mem_read_en=0, mem_write_en=0, write_byte_en=0, mem_addr=0, mem_wdata=0.
- Accept edge = T0. resp_valid rises:
  - Load: 3 cycles after T0.
  - Store: 2 cycles after T0.
  - Error: 1 cycle after T0.
- resp_valid and resp_ready both high at an edge retires the response. req_ready rises in the following cycle, so there is no same-cycle reaccept. Throughput is one load per 4 cycles with resp_ready tied high.
- Backpressure: RESP holds indefinitely with all response outputs unchanged. req_ready stays 0.
- Reset mid-operation: a pending request is discarded with no response, and enables drop asynchronously. A store whose WR edge has not occurred is not written.
- req_* inputs are ignored outside IDLE.

## Test plan
- SB, addr 0x0000_0005, wdata 0x1234_56AB → one WR cycle: mem_addr=1, write_byte_en=0010, mem_wdata=0xABAB_ABAB. resp_valid 2 cycles after accept, resp_rdata=0, resp_err=0.
- Memory word 1 = 0x80FF_7F01. LB at 0x7 → 0xFFFF_FF80. LBU at 0x7 → 0x0000_0080. LH at 0x4 → 0x0000_7F01. LW at 0x4 → 0x80FF_7F01. Each load: resp 3 cycles after accept, mem_read_en high exactly 1 cycle.
- Errors: LH at 0x3, SW at 0x2, and funct3=011 load → resp_err=1 one cycle after accept, mem_read_en and mem_write_en never asserted.
- SH at 0x6, wdata 0xDEAD_BEEF → write_byte_en=1100, mem_wdata=0xBEEF_BEEF. Readback LHU at 0x6 → 0x0000_BEEF.
- Backpressure: hold resp_ready=0 for 5 cycles after a load response → resp_valid/resp_rdata stable, req_ready=0, new req_valid ignored. Release → IDLE next cycle.
- Reset mid-operation: assert rst=0 during RD_ISSUE → mem_read_en drops immediately, req_ready=1, and no resp_valid after release.
